// File: rtl/sid_pkg.sv
// Shared types for the SID request front end.
// Port decode constants, queue entry and front-end state.
package sid_pkg;

  localparam logic [7:0] SID_PORT_ADDR = 8'hCF;
  localparam logic [4:0] SID_RO_FIRST  = 5'h19;

  typedef struct packed {
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
  } sid_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STALL,
    ST_RD_DRAIN,
    ST_RD_REQ,
    ST_RD_DONE
  } sid_state_t;

endpackage

// File: rtl/sid_req_queue_if.sv
// Engine-side request/ack bundle of the SID front end.
// master = request queue, slave = SID bus-cycle engine.
interface sid_req_queue_if;

  logic       req;
  logic       req_wr;
  logic [4:0] req_a;
  logic [7:0] req_d;
  logic       ack;
  logic [7:0] ack_d;

  modport master (
    output req, req_wr, req_a, req_d,
    input  ack, ack_d
  );

  modport slave (
    input  req, req_wr, req_a, req_d,
    output ack, ack_d
  );

endinterface

// File: rtl/sid_req_fifo.sv
// Synchronous FIFO of SID requests.
// Push is dropped when full, pop is dropped when empty.
module sid_req_fifo
  import sid_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  sid_req_t            din,
  output sid_req_t            dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  sid_req_t              mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sid_req_queue.sv
// CPU-side request front end of the SID bridge.
// Define SID_SHADOW_EN to serve write-only register reads from a shadow.
module sid_req_queue
  import sid_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] PORT_ADDR  = SID_PORT_ADDR
) (
  input  logic                clk32,
  input  logic                rst_n,
  input  logic [15:0]         a,
  input  logic [7:0]          d_in,
  input  logic                n_rd,
  input  logic                n_wr,
  input  logic                n_iorq,
  output logic                cpu_wait,
  output logic [7:0]          rd_data,
  sid_req_queue_if.master     eng,
  output logic [DEPTH_LOG2:0] level
);

  sid_state_t state, state_d;
  logic       iowr_q, iowr_q2;
  logic       iord_q, iord_q2;
  logic       wr_edge, rd_edge;
  logic       port_hit;
  logic       cpu_wait_d;
  logic [7:0] rd_data_d;
  logic [4:0] rd_a;
  logic       rd_a_ld;
  sid_req_t   pend;
  logic       pend_ld;
  logic       push, pop;
  logic       full, empty;
  sid_req_t   din, head;
  logic       unused_hi;

  assign unused_hi = ^a[15:13];
  assign port_hit  = (a[7:0] == PORT_ADDR) & ~n_iorq;
  assign wr_edge   = iowr_q & ~iowr_q2;
  assign rd_edge   = iord_q & ~iord_q2;
  assign pop       = eng.ack & ~empty;

  sid_req_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk32),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef SID_SHADOW_EN
  logic [7:0] shadow [32];

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        shadow[i] <= '0;
    end else if (push) begin
      shadow[din.a] <= din.d;
    end
  end
`endif

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      iowr_q   <= 1'b0;
      iowr_q2  <= 1'b0;
      iord_q   <= 1'b0;
      iord_q2  <= 1'b0;
      state    <= ST_IDLE;
      cpu_wait <= 1'b0;
      rd_data  <= '0;
      rd_a     <= '0;
      pend     <= '0;
    end else begin
      iowr_q   <= port_hit & ~n_wr;
      iowr_q2  <= iowr_q;
      iord_q   <= port_hit & ~n_rd;
      iord_q2  <= iord_q;
      state    <= state_d;
      cpu_wait <= cpu_wait_d;
      rd_data  <= rd_data_d;
      if (rd_a_ld)
        rd_a <= a[12:8];
      if (pend_ld)
        pend <= din;
    end
  end

  always_comb begin
    state_d    = state;
    cpu_wait_d = cpu_wait;
    rd_data_d  = rd_data;
    push       = 1'b0;
    pend_ld    = 1'b0;
    rd_a_ld    = 1'b0;
    din        = '{wr: 1'b1, a: a[12:8], d: d_in};
    unique case (state)
      ST_IDLE: begin
        if (wr_edge) begin
          if (!full) begin
            push = 1'b1;
          end else begin
            pend_ld    = 1'b1;
            cpu_wait_d = 1'b1;
            state_d    = ST_WR_STALL;
          end
        end else if (rd_edge) begin
          rd_a_ld    = 1'b1;
          cpu_wait_d = 1'b1;
          state_d    = ST_RD_DRAIN;
`ifdef SID_SHADOW_EN
          if (a[12:8] < SID_RO_FIRST) begin
            rd_data_d = shadow[a[12:8]];
            state_d   = ST_RD_DONE;
          end
`endif
        end
      end
      // full is registered, so a same-cycle ack defers the push
      ST_WR_STALL: begin
        din = pend;
        if (!full) begin
          push       = 1'b1;
          cpu_wait_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_RD_DRAIN: begin
        if (empty)
          state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (eng.ack) begin
          rd_data_d  = eng.ack_d;
          cpu_wait_d = 1'b0;
          state_d    = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        cpu_wait_d = 1'b0;
        if (!iord_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng.req    = 1'b0;
    eng.req_wr = 1'b0;
    eng.req_a  = '0;
    eng.req_d  = '0;
    if (!empty) begin
      eng.req    = 1'b1;
      eng.req_wr = head.wr;
      eng.req_a  = head.a;
      eng.req_d  = head.d;
    end else if (state == ST_RD_REQ) begin
      eng.req    = 1'b1;
      eng.req_a  = rd_a;
    end
  end

endmodule

// File: tb/tb_sid_req_queue.sv
// Directed bench for sid_req_queue.
// Shadow-read vectors run only when SID_SHADOW_EN is defined.
module tb_sid_req_queue;

  logic        clk32 = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        n_rd, n_wr, n_iorq;
  logic        cpu_wait;
  logic [7:0]  rd_data;
  logic [3:0]  level;
  int          n_cmp = 0;
  int          n_bad = 0;

  sid_req_queue_if eng ();

  sid_req_queue #(
    .DEPTH_LOG2(3)
  ) dut (
    .clk32    (clk32),
    .rst_n    (rst_n),
    .a        (a),
    .d_in     (d_in),
    .n_rd     (n_rd),
    .n_wr     (n_wr),
    .n_iorq   (n_iorq),
    .cpu_wait (cpu_wait),
    .rd_data  (rd_data),
    .eng      (eng.master),
    .level    (level)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic ack_pulse(input logic [7:0] v);
    eng.ack   = 1'b1;
    eng.ack_d = v;
    tick();
    eng.ack   = 1'b0;
    eng.ack_d = '0;
  endtask

  task automatic wr_cyc(input logic [4:0] r, input logic [7:0] v);
    a      = {3'b000, r, 8'hCF};
    d_in   = v;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    tick();
    tick();
    n_wr   = 1'b1;
    n_iorq = 1'b1;
    tick();
  endtask

  task automatic rd_start(input logic [4:0] r);
    a      = {3'b000, r, 8'hCF};
    n_iorq = 1'b0;
    n_rd   = 1'b0;
  endtask

  task automatic rd_end();
    n_rd   = 1'b1;
    n_iorq = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    d_in      = '0;
    n_rd      = 1'b1;
    n_wr      = 1'b1;
    n_iorq    = 1'b1;
    eng.ack   = 1'b0;
    eng.ack_d = '0;
    tick();
    tick();
    chk("rst_wait", cpu_wait, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_req", eng.req, 0);
    chk("rst_req_wr", eng.req_wr, 0);
    chk("rst_req_a", eng.req_a, 0);
    chk("rst_req_d", eng.req_d, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    tick();

    // single write: req appears two cycles after the strobe
    a      = 16'h04CF;
    d_in   = 8'h41;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    tick();
    chk("w1_early", eng.req, 0);
    tick();
    chk("w1_req", eng.req, 1);
    chk("w1_wr", eng.req_wr, 1);
    chk("w1_a", eng.req_a, 5'h04);
    chk("w1_d", eng.req_d, 8'h41);
    chk("w1_lvl", level, 1);
    n_wr   = 1'b1;
    n_iorq = 1'b1;
    tick();
    chk("w1_hold", level, 1);
    ack_pulse(8'h00);
    chk("w1_pop", level, 0);
    chk("w1_idle", eng.req, 0);

    ack_pulse(8'h00);
    chk("ack_idle", level, 0);

    // push and pop in the same cycle
    wr_cyc(5'h07, 8'h77);
    chk("pp_pre", level, 1);
    a      = 16'h08CF;
    d_in   = 8'h88;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    tick();
    eng.ack = 1'b1;
    tick();
    eng.ack = 1'b0;
    chk("pp_lvl", level, 1);
    chk("pp_a", eng.req_a, 5'h08);
    chk("pp_d", eng.req_d, 8'h88);
    n_wr   = 1'b1;
    n_iorq = 1'b1;
    tick();
    ack_pulse(8'h00);
    chk("pp_empty", level, 0);

    // nine writes into an eight-entry queue
    for (int i = 0; i < 8; i++)
      wr_cyc(5'(i), 8'(8'h10 + i));
    chk("fill_lvl", level, 8);
    chk("fill_wait", cpu_wait, 0);
    a      = 16'h08CF;
    d_in   = 8'h18;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    tick();
    tick();
    chk("stall_lvl", level, 8);
    chk("stall_wait", cpu_wait, 1);
    n_wr   = 1'b1;
    n_iorq = 1'b1;
    tick();
    chk("stall_hold", cpu_wait, 1);
    ack_pulse(8'h00);
    chk("defer_lvl", level, 7);
    chk("defer_wait", cpu_wait, 1);
    tick();
    chk("push9_lvl", level, 8);
    chk("push9_wait", cpu_wait, 0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d_a", i), eng.req_a, 16'(i));
      chk($sformatf("drain%0d_d", i), eng.req_d, 16'(8'h10 + i));
      ack_pulse(8'h00);
    end
    chk("drain_lvl", level, 0);
    chk("drain_req", eng.req, 0);

    // read waits for queued writes
    wr_cyc(5'h01, 8'hA1);
    wr_cyc(5'h02, 8'hA2);
    wr_cyc(5'h03, 8'hA3);
    rd_start(5'h1B);
    tick();
    tick();
    chk("rd_wait", cpu_wait, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_pre%0d", i), eng.req_wr, 1);
      ack_pulse(8'h00);
    end
    chk("rd_gap", eng.req, 0);
    tick();
    chk("rd_req", eng.req, 1);
    chk("rd_req_wr", eng.req_wr, 0);
    chk("rd_req_a", eng.req_a, 5'h1B);
    chk("rd_hold", cpu_wait, 1);
    ack_pulse(8'h5A);
    chk("rd_data", rd_data, 8'h5A);
    chk("rd_release", cpu_wait, 0);
    chk("rd_req_off", eng.req, 0);
    rd_end();
    tick();
    tick();

    // asynchronous reset with a busy queue
    for (int i = 0; i < 4; i++)
      wr_cyc(5'(5'h0A + i), 8'(8'hC0 + i));
    chk("ar_lvl", level, 4);
    chk("ar_req", eng.req, 1);
    rd_start(5'h1C);
    tick();
    tick();
    chk("ar_wait", cpu_wait, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req0", eng.req, 0);
    chk("ar_lvl0", level, 0);
    chk("ar_wait0", cpu_wait, 0);
    rd_end();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("ar_post_req", eng.req, 0);
    chk("ar_post_lvl", level, 0);
    chk("ar_post_wait", cpu_wait, 0);

`ifdef SID_SHADOW_EN
    wr_cyc(5'h18, 8'h0F);
    ack_pulse(8'h00);
    chk("sh_empty", level, 0);
    rd_start(5'h18);
    tick();
    tick();
    chk("sh_wait", cpu_wait, 1);
    chk("sh_data", rd_data, 8'h0F);
    chk("sh_noreq", eng.req, 0);
    tick();
    chk("sh_release", cpu_wait, 0);
    chk("sh_noreq2", eng.req, 0);
    rd_end();
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sid_req_queue.md
# sid_req_queue

CPU-side request front end for the SID bridge. It sits between the Z80 I/O bus decode and the SID bus-cycle engine. Port 0xCF writes go into a small FIFO so the CPU continues without waiting for the slow SID clock phase. Reads hold the CPU with wait until every earlier write has drained, then issue one read request downstream. The engine consumes the FIFO head through a req/ack handshake and drives the physical SID pins.

## Interface
Parameters:
- DEPTH_LOG2, 3: FIFO depth = 2^DEPTH_LOG2 entries.
- PORT_ADDR, 8'hCF: low address byte that decodes the SID port.

Ports:
- clk32  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- a  in  16  Z80 address; a[7:0] decode, a[12:8] SID register.
- d_in  in  8  Z80 data bus, sampled on writes.
- n_rd, n_wr, n_iorq  in  1 each  Z80 strobes, active-low, asynchronous to clk32.
- cpu_wait  out  1  high = hold Z80; the top converts it to open-drain n_wait.
- rd_data  out  8  read result; the top drives it onto d during port reads.
- req  out  1  engine request valid.
- req_wr  out  1  1 = write cycle, 0 = read cycle.
- req_a  out  5  SID register address.
- req_d  out  8  write data; don't-care on reads.
- ack  in  1  one-cycle pulse from the engine: the SID cycle is complete.
- ack_d  in  8  read data from the SID; valid while ack is high.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.

## Operation
- Strobe capture: iowr/iord are registered once from the decode (port match, n_iorq low, strobe low). An access is recognised on the 0→1 edge of the registered signal. One bus cycle produces exactly one access.
- Write path:
  - Not full: push {a[12:8], d_in} in the edge cycle.
  - Full: raise cpu_wait, hold in WR_STALL, push on the first cycle with level < depth, then drop cpu_wait.
  - The full test uses registered level. An ack in the same cycle does not permit the push; it succeeds one cycle later.
- Engine side:
  - req = FIFO non-empty, or a read is outstanding; fields come from the head entry.
  - Fields stay stable while req is high.
  - ack pops the head. req may reassert the cycle after ack.
  - ack while req is low is ignored.
- Push and pop in the same cycle: level unchanged. Empty-plus-push raises req the next cycle.
- Read FSM:
  - IDLE: on an iord edge, set cpu_wait=1 and go to RD_DRAIN.
  - RD_DRAIN: wait for level==0 with no write in flight, then go to RD_REQ.
  - RD_REQ: req=1, req_wr=0, req_a=a[12:8]. On ack, latch ack_d into rd_data, set cpu_wait=0, go to RD_DONE.
  - RD_DONE: return to IDLE when the registered iord is low.
- A write edge while the read FSM is not IDLE cannot occur on a Z80 bus. If it does occur, it is ignored.
- Pointers wrap modulo depth. level is never above depth and never below 0.

## Timing
- Reset values: cpu_wait=0, rd_data=0, req=0, req_wr=0, req_a=0, req_d=0, level=0, FSM=IDLE.
- Reset mid-operation clears the FIFO and drops req and cpu_wait immediately (asynchronous). An in-flight engine cycle is abandoned.
- Write latency: strobe edge at the flop input (cycle N) → registered (N+1) → push (N+1) → req visible at N+2 if the FIFO was empty.
- Read latency: engine time plus 2 cycles. cpu_wait falls the cycle after ack.

## Configuration
- SID_SHADOW_EN defined:
  - A 32×8 shadow register file captures every pushed write, indexed by address.
  - Reads of addresses 0x00–0x18 (write-only SID registers) are served from the shadow.
  - Served path: in the edge cycle, load rd_data from the shadow and raise cpu_wait; release it the next cycle. No drain and no engine request.
  - Addresses 0x19–0x1F use the normal read path.
  - Shadow resets to 0.
- Undefined: all reads take the engine path, and no shadow storage is built.

## Structure
- Package sid_pkg holds:
  - SID_PORT_ADDR (8'hCF) and SID_RO_FIRST (5'h19).
  - typedef sid_req_t {wr, a[4:0], d[7:0]}.
  - typedef for the read-FSM state enum.
- One sub-module, sid_req_fifo:
  - Synchronous FIFO of sid_req_t with push/pop/full/empty/level.
  - Holds the wrap and simultaneous push/pop rules.

## Test plan
- Single write a=0x04CF, d=0x41 → one req with req_wr=1, req_a=0x04, req_d=0x41, 2 cycles after the strobe edge; level goes 1→0 on ack.
- Nine back-to-back writes with ack withheld, DEPTH_LOG2=3 → level=8 and cpu_wait=1 on the ninth; one ack → ninth pushed the next cycle, cpu_wait falls, and order is preserved on drain.
- Three queued writes, then a read of 0x1B with ack_d=0x5A → read req issued only after the third write's ack; rd_data=0x5A; cpu_wait low the cycle after ack.
- SID_SHADOW_EN: write 0x18←0x0F, then read 0x18 → rd_data=0x0F, cpu_wait high for exactly 1 cycle, no read req.
- rst_n pulled low with 4 entries queued and req high → req=0, level=0, cpu_wait=0 immediately; no req after release.
- ack in the same cycle as a push while full → push deferred one cycle, level back at 8, no entry lost.
